// File: rtl/row_accum_ctrl_if.sv
// Bus bundle for row_accum_ctrl: pass control, edge/product memory ports and row readout.
interface row_accum_ctrl_if #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned NUM_EDGES      = 8,
  parameter int unsigned FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int unsigned EDGE_WIDTH     = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
);
  localparam int unsigned ROW_W = WEIGHT_COLS * DOT_PROD_WIDTH;

  logic                     start;
  logic [EDGE_WIDTH-1:0]    coo_addr;
  logic [FEATURE_WIDTH-1:0] coo_src;
  logic [FEATURE_WIDTH-1:0] coo_dst;
  logic [FEATURE_WIDTH-1:0] fm_wm_addr;
  logic [ROW_W-1:0]         fm_wm_data;
  logic [FEATURE_WIDTH-1:0] rd_row_addr;
  logic [ROW_W-1:0]         rd_row_data;
  logic                     busy;
  logic                     done;
  logic                     edge_err;

  modport slave (
    input  start, coo_src, coo_dst, fm_wm_data, rd_row_addr,
    output coo_addr, fm_wm_addr, rd_row_data, busy, done, edge_err
  );

  modport master (
    output start, coo_src, coo_dst, fm_wm_data, rd_row_addr,
    input  coo_addr, fm_wm_addr, rd_row_data, busy, done, edge_err
  );
endinterface

// File: rtl/row_accum_ctrl.sv
// Graph aggregation controller: walks a COO edge list and sums product rows
// of each edge source into the accumulation row of its destination.
module row_accum_ctrl #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned NUM_EDGES      = 8,
  parameter int unsigned FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int unsigned EDGE_WIDTH     = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  row_accum_ctrl_if.slave   bus
);
  localparam int unsigned ROW_W = WEIGHT_COLS * DOT_PROD_WIDTH;

  typedef enum logic [2:0] {IDLE, CLEAR, EDGE_RD, ROW_RD, ACCUM, DONE} state_e;

  state_e                    state_q, state_d;
  logic [EDGE_WIDTH-1:0]     edge_idx_q, edge_idx_d;
  logic [FEATURE_WIDTH-1:0]  row_idx_q, row_idx_d;
  logic [FEATURE_WIDTH-1:0]  src_q, src_d;
  logic [FEATURE_WIDTH-1:0]  dst_q, dst_d;
  logic [EDGE_WIDTH-1:0]     coo_addr_q, coo_addr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      edge_err_q, edge_err_d;
  logic [DOT_PROD_WIDTH-1:0] acc_q [FEATURE_ROWS][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0] acc_d [FEATURE_ROWS][WEIGHT_COLS];
  logic                      in_edge_ok_c;
  logic                      cap_edge_ok_c;
  logic [ROW_W-1:0]          rd_row_c;

  assign in_edge_ok_c  = (32'(bus.coo_src) < FEATURE_ROWS) && (32'(bus.coo_dst) < FEATURE_ROWS);
  assign cap_edge_ok_c = (32'(src_q) < FEATURE_ROWS) && (32'(dst_q) < FEATURE_ROWS);

  // Next-state, counters and accumulator update
  always_comb begin
    state_d    = state_q;
    edge_idx_d = edge_idx_q;
    row_idx_d  = row_idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    edge_err_d = edge_err_q;
    acc_d      = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CLEAR;
          edge_err_d = 1'b0;
          edge_idx_d = '0;
          row_idx_d  = '0;
        end
      end
      CLEAR: begin
        for (int r = 0; r < FEATURE_ROWS; r++) begin
          if (row_idx_q == FEATURE_WIDTH'(r)) begin
            for (int c = 0; c < WEIGHT_COLS; c++) acc_d[r][c] = '0;
          end
        end
        if (32'(row_idx_q) == FEATURE_ROWS - 1) state_d = EDGE_RD;
        else row_idx_d = row_idx_q + FEATURE_WIDTH'(1);
      end
      EDGE_RD: state_d = ROW_RD;
      ROW_RD: begin
        src_d   = bus.coo_src;
        dst_d   = bus.coo_dst;
        state_d = ACCUM;
        if (!in_edge_ok_c) edge_err_d = 1'b1;
      end
      ACCUM: begin
        // Out-of-range edges still take their slot but leave acc untouched
        if (cap_edge_ok_c) begin
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (dst_q == FEATURE_WIDTH'(r)) begin
              for (int c = 0; c < WEIGHT_COLS; c++)
                acc_d[r][c] = acc_q[r][c] + bus.fm_wm_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
            end
          end
        end
        if (32'(edge_idx_q) == NUM_EDGES - 1) state_d = DONE;
        else begin
          edge_idx_d = edge_idx_q + EDGE_WIDTH'(1);
          state_d    = EDGE_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    coo_addr_d = (state_d == EDGE_RD) ? edge_idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      edge_idx_q <= '0;
      row_idx_q  <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      coo_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_err_q <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++)
        for (int c = 0; c < WEIGHT_COLS; c++) acc_q[r][c] <= '0;
    end else begin
      state_q    <= state_d;
      edge_idx_q <= edge_idx_d;
      row_idx_q  <= row_idx_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      coo_addr_q <= coo_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edge_err_q <= edge_err_d;
      acc_q      <= acc_d;
    end
  end

  // Readout mux; rows beyond FEATURE_ROWS read as zero
  always_comb begin
    rd_row_c = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (bus.rd_row_addr == FEATURE_WIDTH'(r)) begin
        for (int c = 0; c < WEIGHT_COLS; c++)
          rd_row_c[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = acc_q[r][c];
      end
    end
  end

  // Product address must follow coo_src in the same cycle so data lands in ACCUM
  assign bus.fm_wm_addr  = (state_q == ROW_RD) ? bus.coo_src : '0;
  assign bus.coo_addr    = coo_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.edge_err    = edge_err_q;
  assign bus.rd_row_data = rd_row_c;
endmodule

// File: tb/tb_row_accum_ctrl.sv
// Self-checking bench for row_accum_ctrl: random edge lists and product rows
// compared against a direct edge-by-edge sum model.
module tb_row_accum_ctrl;
  localparam int unsigned FR  = 6;
  localparam int unsigned WC  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned NE  = 8;
  localparam int unsigned NE4 = 4;
  localparam int LAT  = 1 + FR + 3*NE;
  localparam int LAT4 = 1 + FR + 3*NE4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  row_accum_ctrl_if #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .NUM_EDGES(NE))  bus ();
  row_accum_ctrl_if #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .NUM_EDGES(NE4)) bus4 ();

  row_accum_ctrl #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .NUM_EDGES(NE))
    dut (.clk(clk), .reset(reset), .bus(bus));
  row_accum_ctrl #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .NUM_EDGES(NE4))
    dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic [2:0]  e_src [NE];
  logic [2:0]  e_dst [NE];
  logic [2:0]  e4_src [NE4];
  logic [2:0]  e4_dst [NE4];
  logic [47:0] prod [8];

  // One-cycle-latency edge and product memories
  always @(posedge clk) begin
    bus.coo_src     <= e_src[bus.coo_addr];
    bus.coo_dst     <= e_dst[bus.coo_addr];
    bus.fm_wm_data  <= prod[bus.fm_wm_addr];
    bus4.coo_src    <= e4_src[bus4.coo_addr];
    bus4.coo_dst    <= e4_dst[bus4.coo_addr];
    bus4.fm_wm_data <= prod[bus4.fm_wm_addr];
  end

  int total = 0;
  int bad   = 0;
  int exp_acc [FR][WC];
  bit exp_err;

  function automatic void model_pass();
    exp_err = 1'b0;
    for (int r = 0; r < FR; r++) for (int c = 0; c < WC; c++) exp_acc[r][c] = 0;
    for (int e = 0; e < NE; e++) begin
      int s = int'(e_src[e]);
      int d = int'(e_dst[e]);
      if (s < FR && d < FR) begin
        for (int c = 0; c < WC; c++)
          exp_acc[d][c] = (exp_acc[d][c] + int'(prod[s][c*DW +: DW])) % 65536;
      end else exp_err = 1'b1;
    end
  endfunction

  function automatic logic [47:0] exp_row(input int r);
    logic [47:0] v = '0;
    if (r < FR) for (int c = 0; c < WC; c++) v[c*DW +: DW] = 16'(exp_acc[r][c]);
    return v;
  endfunction

  function automatic logic [47:0] rand_row();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  // mode 0: plain pass; 1: extra start in ACCUM of edge 0; 2: stop in ROW_RD of edge 4
  task automatic run_pass(input int mode, output int lat, output int ndone);
    lat = 0; ndone = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    for (int m = 1; m <= LAT + 3; m++) begin
      @(negedge clk);
      bus.start = (mode == 1 && m == 9);
      if (mode == 2 && m == 20) return;
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = m;
      end
    end
  endtask

  task automatic test_reset();
    total++; if ({bus.busy, bus.done, bus.edge_err} !== 3'b000) begin bad++;
      $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.edge_err}); end
    total++; if ({bus.coo_addr, bus.fm_wm_addr} !== 6'd0) begin bad++;
      $display("FAIL reset_addr: got %h want 0", {bus.coo_addr, bus.fm_wm_addr}); end
    total++; if ({bus4.busy, bus4.done, bus4.edge_err} !== 3'b000) begin bad++;
      $display("FAIL reset_flags4: got %b want 000", {bus4.busy, bus4.done, bus4.edge_err}); end
    for (int r = 0; r < 8; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== 48'd0) begin bad++;
        $display("FAIL reset_row%0d: got %h want 0", r, bus.rd_row_data); end
    end
  endtask

  task automatic test_defaults();
    int lat = 0, nd = 0;
    logic [47:0] want;
    for (int r = 0; r < 8; r++) prod[r] = {16'(100*(r+1)), 16'(10*(r+1)), 16'(r+1)};
    e4_src[0] = 3'd0; e4_dst[0] = 3'd1;
    e4_src[1] = 3'd2; e4_dst[1] = 3'd1;
    e4_src[2] = 3'd1; e4_dst[2] = 3'd1;
    e4_src[3] = 3'd5; e4_dst[3] = 3'd0;
    @(negedge clk); bus4.start = 1'b1;
    @(posedge clk);
    for (int m = 1; m <= LAT4 + 3; m++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (bus4.done === 1'b1) begin nd++; if (lat == 0) lat = m; end
    end
    total++; if (lat != LAT4) begin bad++; $display("FAIL def_latency: got %0d want %0d", lat, LAT4); end
    total++; if (nd != 1) begin bad++; $display("FAIL def_done_count: got %0d want 1", nd); end
    total++; if (bus4.edge_err !== 1'b0) begin bad++; $display("FAIL def_edge_err: got %b want 0", bus4.edge_err); end
    for (int r = 0; r < 8; r++) begin
      want = (r <= 1) ? {16'd600, 16'd60, 16'd6} : 48'd0;
      bus4.rd_row_addr = 3'(r); #1;
      total++; if (bus4.rd_row_data !== want) begin bad++;
        $display("FAIL def_row%0d: got %h want %h", r, bus4.rd_row_data, want); end
    end
  endtask

  task automatic test_random(input int iters);
    int lat, nd;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 8; i++) prod[i] = rand_row();
      for (int e = 0; e < NE; e++) begin
        e_src[e] = 3'($urandom_range(0, (it == 0) ? 5 : 7));
        e_dst[e] = 3'($urandom_range(0, (it == 0) ? 5 : 7));
      end
      model_pass();
      run_pass(0, lat, nd);
      total++; if (lat != LAT) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, LAT); end
      total++; if (nd != 1) begin bad++; $display("FAIL rand%0d_done_count: got %0d want 1", it, nd); end
      total++; if (bus.edge_err !== exp_err) begin bad++;
        $display("FAIL rand%0d_edge_err: got %b want %b", it, bus.edge_err, exp_err); end
      for (int r = 0; r < 8; r++) begin
        bus.rd_row_addr = 3'(r); #1;
        total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
          $display("FAIL rand%0d_row%0d: got %h want %h", it, r, bus.rd_row_data, exp_row(r)); end
      end
    end
  endtask

  task automatic test_bad_edges();
    int lat, nd;
    logic [2:0] s [NE] = '{3'd0, 3'd6, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd3};
    logic [2:0] d [NE] = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd5, 3'd5, 3'd0, 3'd3};
    for (int i = 0; i < 8; i++) prod[i] = rand_row();
    for (int e = 0; e < NE; e++) begin e_src[e] = s[e]; e_dst[e] = d[e]; end
    model_pass();
    run_pass(0, lat, nd);
    total++; if (bus.edge_err !== 1'b1) begin bad++; $display("FAIL bad_edge_err: got %b want 1", bus.edge_err); end
    for (int r = 0; r < 8; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
        $display("FAIL bad_row%0d: got %h want %h", r, bus.rd_row_data, exp_row(r)); end
    end
  endtask

  task automatic test_wrap();
    int lat, nd;
    logic [2:0] s [NE] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd4};
    logic [2:0] d [NE] = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4};
    for (int i = 0; i < 8; i++) prod[i] = rand_row();
    prod[0] = {3{16'hFFFF}};
    prod[1] = {3{16'h0002}};
    for (int e = 0; e < NE; e++) begin e_src[e] = s[e]; e_dst[e] = d[e]; end
    model_pass();
    run_pass(0, lat, nd);
    bus.rd_row_addr = 3'd3; #1;
    total++; if (bus.rd_row_data !== {3{16'h0001}}) begin bad++;
      $display("FAIL wrap_row3: got %h want %h", bus.rd_row_data, {3{16'h0001}}); end
    for (int r = 0; r < FR; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
        $display("FAIL wrap_row%0d: got %h want %h", r, bus.rd_row_data, exp_row(r)); end
    end
  endtask

  task automatic test_start_in_accum();
    int lat, nd;
    for (int i = 0; i < 8; i++) prod[i] = rand_row();
    for (int e = 0; e < NE; e++) begin e_src[e] = 3'($urandom_range(0, 5)); e_dst[e] = 3'($urandom_range(0, 5)); end
    model_pass();
    run_pass(1, lat, nd);
    total++; if (lat != LAT) begin bad++; $display("FAIL restart_latency: got %0d want %0d", lat, LAT); end
    total++; if (nd != 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL restart_busy_after: got %b want 0", bus.busy); end
    for (int r = 0; r < FR; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
        $display("FAIL restart_row%0d: got %h want %h", r, bus.rd_row_data, exp_row(r)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    for (int i = 0; i < 8; i++) prod[i] = rand_row();
    for (int e = 0; e < NE; e++) begin e_src[e] = 3'($urandom_range(0, 5)); e_dst[e] = 3'($urandom_range(0, 5)); end
    e_src[1] = 3'd7;
    run_pass(2, lat, nd);
    total++; if (bus.fm_wm_addr !== e_src[4]) begin bad++;
      $display("FAIL midrst_rowrd_addr: got %0d want %0d", bus.fm_wm_addr, e_src[4]); end
    total++; if (bus.edge_err !== 1'b1) begin bad++; $display("FAIL midrst_err_before: got %b want 1", bus.edge_err); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.edge_err} !== 3'b000) begin bad++;
      $display("FAIL midrst_flags: got %b want 000", {bus.busy, bus.done, bus.edge_err}); end
    total++; if ({bus.coo_addr, bus.fm_wm_addr} !== 6'd0) begin bad++;
      $display("FAIL midrst_addr: got %h want 0", {bus.coo_addr, bus.fm_wm_addr}); end
    for (int r = 0; r < FR; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== 48'd0) begin bad++;
        $display("FAIL midrst_row%0d: got %h want 0", r, bus.rd_row_data); end
    end
    reset = 1'b0;
    e_src[1] = 3'd2;
    model_pass();
    run_pass(0, lat, nd);
    total++; if (lat != LAT) begin bad++; $display("FAIL midrst_new_latency: got %0d want %0d", lat, LAT); end
    for (int r = 0; r < FR; r++) begin
      bus.rd_row_addr = 3'(r); #1;
      total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
        $display("FAIL midrst_new_row%0d: got %h want %h", r, bus.rd_row_data, exp_row(r)); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    for (int e = 0; e < NE; e++) begin e_src[e] = 3'($urandom_range(0, 5)); e_dst[e] = 3'($urandom_range(0, 5)); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) prod[i] = rand_row();
      model_pass();
      run_pass(0, lat, nd);
      total++; if (nd != 1) begin bad++; $display("FAIL b2b%0d_done_count: got %0d want 1", p, nd); end
      for (int r = 0; r < FR; r++) begin
        bus.rd_row_addr = 3'(r); #1;
        total++; if (bus.rd_row_data !== exp_row(r)) begin bad++;
          $display("FAIL b2b%0d_row%0d: got %h want %h", p, r, bus.rd_row_data, exp_row(r)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;  bus.rd_row_addr = '0;
    bus4.start = 1'b0; bus4.rd_row_addr = '0;
    for (int i = 0; i < 8; i++) prod[i] = '0;
    for (int e = 0; e < NE; e++) begin e_src[e] = '0; e_dst[e] = '0; end
    for (int e = 0; e < NE4; e++) begin e4_src[e] = '0; e4_dst[e] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_defaults();
    test_random(4);
    test_bad_edges();
    test_wrap();
    test_start_in_accum();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
